// File: rtl/axis_fifo_pkg.sv
// Shared defaults and entry layout for the AXI4-Stream data FIFO.
package axis_fifo_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefDepth     = 16;

  typedef struct packed {
    logic                    tlast;
    logic [DefDataWidth-1:0] tdata;
  } axis_entry_t;

endpackage

// File: rtl/axis_fifo_core.sv
// Circular-buffer storage with pointers, occupancy count and registered full/empty flags.
module axis_fifo_core #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             not_full_o,
  output logic             not_empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             not_full_q, not_empty_q;
  logic             do_push, do_pop;

  // Flags gate the requests so a full FIFO never accepts, even with a same-cycle pop.
  assign do_push = push_i && not_full_q;
  assign do_pop  = pop_i && not_empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      not_full_q  <= 1'b0;
      not_empty_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      not_full_q  <= (count_d != CntW'(Depth));
      not_empty_q <= (count_d != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign not_full_o  = not_full_q;
  assign not_empty_o = not_empty_q;

endmodule

// File: rtl/simulation_wrapper.sv
// AXI4-Stream data FIFO wrapper; define AXIS_FIFO_PACKET_MODE_EN to release data only
// once a complete packet is buffered (or the FIFO is full).
module simulation_wrapper
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  typedef struct packed {
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
  } entry_t;

  entry_t wr_entry, head;
  logic   core_not_full, core_not_empty;
  logic   push, pop;

  assign wr_entry = '{tlast: s_axis_tlast, tdata: s_axis_tdata};
  assign push     = s_axis_tvalid && s_axis_tready;
  assign pop      = m_axis_tvalid && m_axis_tready;

  axis_fifo_core #(
    .Width ($bits(entry_t)),
    .Depth (DEPTH)
  ) u_core (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .push_i      (push),
    .wdata_i     (wr_entry),
    .pop_i       (pop),
    .rdata_o     (head),
    .not_full_o  (core_not_full),
    .not_empty_o (core_not_empty)
  );

  assign s_axis_tready = core_not_full;
  assign m_axis_tdata  = head.tdata;
  assign m_axis_tlast  = core_not_empty && head.tlast;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [CntW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic            push_last, pop_last;

  assign push_last = push && s_axis_tlast;
  assign pop_last  = pop && head.tlast;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({push_last, pop_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CntW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CntW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) pkt_cnt_q <= '0;
    else          pkt_cnt_q <= pkt_cnt_d;
  end

  // A full FIFO with no tlast would otherwise stall forever, so release it anyway.
  assign m_axis_tvalid = core_not_empty && ((pkt_cnt_q != '0) || !core_not_full);
`else
  assign m_axis_tvalid = core_not_empty;
`endif

endmodule

// File: tb/tb_simulation_wrapper.sv
// Directed self-checking bench for the AXI4-Stream data FIFO wrapper.
module tb_simulation_wrapper;

  localparam int unsigned DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  simulation_wrapper #(
    .DATA_WIDTH (DW),
    .DEPTH      (16)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consume n beats first..first+n-1 with tready held high; tlast expected at index last_at.
  task automatic drain(input int first, input int n, input int last_at);
    int got = 0;
    m_tready = 1'b1;
    for (int c = 0; c < n + 10 && got < n; c++) begin
      if (m_tvalid) begin
        chk("drain_data", 64'(m_tdata), 64'(first + got));
        chk("drain_last", 64'(m_tlast), 64'(got == last_at));
        got++;
      end
      tick();
    end
    chk("drain_count", 64'(got), 64'(n));
    chk("drain_empty", 64'(m_tvalid), 64'(0));
    m_tready = 1'b0;
  endtask

  // Stream n beats straight through a FIFO that is empty on entry.
  task automatic send_burst(input int first, input int n);
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    chk("burst_no_passthru", 64'(m_tvalid), 64'(0));
    for (int i = 0; i < n; i++) begin
      s_tdata = DW'(first + i);
      s_tlast = (i == n - 1);
      chk("burst_ready", 64'(s_tready), 64'(1));
      tick();
      chk("burst_valid", 64'(m_tvalid), 64'(1));
      chk("burst_data", 64'(m_tdata), 64'(first + i));
      chk("burst_last", 64'(m_tlast), 64'(i == n - 1));
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    tick();
    chk("burst_done_valid", 64'(m_tvalid), 64'(0));
    chk("burst_done_last", 64'(m_tlast), 64'(0));
    m_tready = 1'b0;
  endtask

  initial begin
    // Reset and release between edges
    tick();
    chk("rst_tready", 64'(s_tready), 64'(0));
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tlast", 64'(m_tlast), 64'(0));
    #2 aresetn = 1'b1;
    #1 chk("rel_tready_before_edge", 64'(s_tready), 64'(0));
    tick();
    chk("rel_tready", 64'(s_tready), 64'(1));
    chk("rel_tvalid", 64'(m_tvalid), 64'(0));

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // Held until the tlast beat lands
    s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tdata = DW'(32'h20 + i);
      s_tlast = (i == 3);
      tick();
      chk("pkt_valid", 64'(m_tvalid), 64'(i == 3));
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    drain(32'h20, 4, 3);

    // No tlast at all: released only once full
    s_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_tdata = DW'(32'h40 + i);
      tick();
      chk("pkt_full_valid", 64'(m_tvalid), 64'(i == 15));
    end
    s_tvalid = 1'b0;
    chk("pkt_full_tready", 64'(s_tready), 64'(0));
    chk("pkt_full_head", 64'(m_tdata), 64'(32'h40));
`else
    // Burst pass-through
    send_burst(0, 16);

    // Fill and backpressure
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_tdata = DW'(i);
      chk("fill_ready", 64'(s_tready), 64'(1));
      tick();
    end
    chk("full_tready", 64'(s_tready), 64'(0));
    s_tdata = DW'(16);
    tick();
    chk("full_hold_tready", 64'(s_tready), 64'(0));
    chk("full_hold_data", 64'(m_tdata), 64'(0));
    chk("full_hold_valid", 64'(m_tvalid), 64'(1));
    m_tready = 1'b1;
    tick();
    chk("full_pop_tready", 64'(s_tready), 64'(1));
    chk("full_pop_data", 64'(m_tdata), 64'(1));
    tick();
    s_tvalid = 1'b0;
    drain(2, 15, -1);

    // Simultaneous push/pop at occupancy 8
    s_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_tdata = DW'(100 + i);
      tick();
    end
    m_tready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      s_tdata = DW'(108 + j);
      chk("sim_data", 64'(m_tdata), 64'(100 + j));
      chk("sim_tready", 64'(s_tready), 64'(1));
      chk("sim_tvalid", 64'(m_tvalid), 64'(1));
      tick();
    end
    s_tvalid = 1'b0;
    drain(120, 8, -1);

    // Mid-stream reset
    s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_tdata = DW'(32'h50 + i);
      tick();
    end
    s_tvalid = 1'b0;
    chk("mid_valid_before", 64'(m_tvalid), 64'(1));
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("mid_rst_tready", 64'(s_tready), 64'(0));
    chk("mid_rst_tlast", 64'(m_tlast), 64'(0));
    @(posedge aclk);
    #2 aresetn = 1'b1;
    tick();
    chk("mid_rel_tready", 64'(s_tready), 64'(1));
    chk("mid_rel_tvalid", 64'(m_tvalid), 64'(0));
    send_burst(32'hA, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
